// File: rtl/macro_test_pkg.sv
// Shared types and helpers for the macro test sequencer: FSM states, widths,
// default feedback taps / timeout, and the Galois step used by LFSR and MISR.
package macro_test_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned DEF_TIMEOUT = 15;
    localparam logic [DATA_W-1:0] DEF_POLY = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP,
        HOLD,
        DONE,
        ERR
    } state_e;

    // One right-shift Galois step with feedback taps 'poly'.
    function automatic logic [DATA_W-1:0] galois_step(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] poly
    );
        return (x >> 1) ^ (x[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/macro_test_lfsr.sv
// Seedable Galois LFSR vector generator; a zero seed is replaced by 1 so the
// sequence never locks up.
module macro_test_lfsr
    import macro_test_pkg::*;
#(
    parameter logic [DATA_W-1:0] POLY = DEF_POLY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              adv,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == '0) ? DATA_W'(1) : seed;
        end else if (adv) begin
            lfsr_d = galois_step(lfsr_q, POLY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/macro_test_sequencer.sv
// BIST sequencer for the macro under test: issues LFSR vectors over req/ack,
// folds responses into a MISR, flags timeouts. MACRO_TEST_STEP_EN adds a HOLD
// state that waits for a step pulse between vectors.
module macro_test_sequencer
    import macro_test_pkg::*;
#(
    parameter int unsigned       TIMEOUT = DEF_TIMEOUT,
    parameter logic [DATA_W-1:0] POLY    = DEF_POLY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic              step,
    output logic              mac_req,
    output logic [DATA_W-1:0] mac_din,
    input  logic              mac_ack,
    input  logic [DATA_W-1:0] mac_dout,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  vec_count,
    output logic [DATA_W-1:0] signature
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              start_q;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  num_vec_q, num_vec_d;
    logic [CNT_W-1:0]  vec_count_q, vec_count_d;
    logic [DATA_W-1:0] signature_q, signature_d;
    logic              mac_req_q, mac_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_err_q, timeout_err_d;
    logic              start_edge;
    logic              last_vec;
    logic              lfsr_load, lfsr_adv;

`ifndef MACRO_TEST_STEP_EN
    logic step_unused;
    assign step_unused = step;
`endif

    macro_test_lfsr #(.POLY(POLY)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (seed),
        .adv   (lfsr_adv),
        .value (mac_din)
    );

    assign start_edge = start & ~start_q;
    assign last_vec   = (vec_count_q == num_vec_q);

    // Next state, datapath updates; outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        num_vec_d   = num_vec_q;
        vec_count_d = vec_count_q;
        signature_d = signature_q;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_edge) begin
                    num_vec_d   = num_vec;
                    lfsr_load   = 1'b1;
                    signature_d = '0;
                    vec_count_d = '0;
                    state_d     = (num_vec == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // An ack on the final allowed cycle still completes the vector.
                if (mac_ack) begin
                    signature_d = galois_step(signature_q, POLY) ^ mac_dout;
                    vec_count_d = vec_count_q + CNT_W'(1);
                    lfsr_adv    = 1'b1;
                    state_d     = GAP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (timer_d == TMR_W'(TIMEOUT)) begin
                        state_d = ERR;
                    end
                end
            end
            GAP: begin
`ifdef MACRO_TEST_STEP_EN
                state_d = HOLD;
`else
                state_d = last_vec ? DONE : ISSUE;
`endif
            end
`ifdef MACRO_TEST_STEP_EN
            HOLD: begin
                if (step) begin
                    state_d = last_vec ? DONE : ISSUE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        mac_req_d     = (state_d == ISSUE) || (state_d == WAIT);
        busy_d        = (state_d == ISSUE) || (state_d == WAIT) ||
                        (state_d == GAP)   || (state_d == HOLD);
        done_d        = (state_d == DONE) || (state_d == ERR);
        timeout_err_d = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            timer_q       <= '0;
            num_vec_q     <= '0;
            vec_count_q   <= '0;
            signature_q   <= '0;
            mac_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start;
            timer_q       <= timer_d;
            num_vec_q     <= num_vec_d;
            vec_count_q   <= vec_count_d;
            signature_q   <= signature_d;
            mac_req_q     <= mac_req_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mac_req     = mac_req_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign vec_count   = vec_count_q;
    assign signature   = signature_q;

endmodule

// File: tb/tb_macro_test_sequencer.sv
// Self-checking bench for macro_test_sequencer: a behavioural macro with
// configurable ack latency and response key, plus a transaction-level model.
module tb_macro_test_sequencer;

    localparam int TIMEOUT = 15;
    localparam int BOUND   = 4000;
`ifdef MACRO_TEST_STEP_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start, step, mac_req, mac_ack, busy, done, timeout_err;
    logic [7:0] seed, num_vec, mac_din, mac_dout, vec_count, signature;

    macro_test_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .seed        (seed),
        .num_vec     (num_vec),
        .step        (step),
        .mac_req     (mac_req),
        .mac_din     (mac_din),
        .mac_ack     (mac_ack),
        .mac_dout    (mac_dout),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .vec_count   (vec_count),
        .signature   (signature)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seed;
        int         n;
        int         lat;
        logic [7:0] key;
        bit         poke;
        logic [7:0] exp_sig;
        int         exp_cnt;
        bit         exp_err;
    } tv_t;

    int         checks = 0;
    int         errors = 0;
    int         cur_lat = 2;
    logic [7:0] cur_key = 8'h00;
    logic [7:0] got[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gstep(input logic [7:0] x);
        return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
    endfunction

    // Transaction-level expectation: vectors issued, final signature, count, error.
    task automatic ref_run(input logic [7:0] sd, input int n, input int lat, input logic [7:0] key,
                           output logic [7:0] sig, output int cnt, output bit err,
                           output logic [7:0] vecs[$]);
        logic [7:0] v;
        v = (sd == 8'h00) ? 8'h01 : sd;
        sig = 8'h00; cnt = 0; err = 1'b0; vecs.delete();
        if (n > 0 && lat > TIMEOUT) begin
            err = 1'b1;
            vecs.push_back(v);
        end else begin
            for (int i = 0; i < n; i++) begin
                vecs.push_back(v);
                sig = gstep(sig) ^ (v ^ key);
                v = gstep(v);
                cnt++;
            end
        end
    endtask

    // Behavioural macro: acks on the lat-th WAIT cycle, responds with din ^ key.
    initial begin : macro_model
        int rc;
        rc = 0; mac_ack = 1'b0; mac_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (mac_req) begin
                rc++;
                if (rc == 1) got.push_back(mac_din);
                mac_ack  = (rc == cur_lat + 1);
                mac_dout = mac_ack ? (mac_din ^ cur_key) : 8'($urandom);
            end else begin
                rc = 0;
                mac_ack  = 1'b0;
                mac_dout = 8'($urandom);
            end
        end
    end

`ifndef MACRO_TEST_STEP_EN
    initial begin : step_noise
        forever begin
            @(negedge clk);
            step = 1'($urandom);
        end
    end
`endif

    task automatic run(input tv_t t, input string tag);
        logic [7:0] vecs[$];
        logic [7:0] msig;
        int mcnt, cyc, exp_cyc;
        bit merr;
        ref_run(t.seed, t.n, t.lat, t.key, msig, mcnt, merr, vecs);
        got.delete();
        cur_lat = t.lat;
        cur_key = t.key;
        @(negedge clk);
        seed = t.seed; num_vec = 8'(t.n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < BOUND) begin
            if (t.poke && busy) begin
                start = ~start;
                seed = 8'($urandom);
                num_vec = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        exp_cyc = merr ? TIMEOUT + 2 : t.n * (t.lat + 2 + EXTRA) + 1;
        chk({tag, " done"}, int'(done), 1);
        chk({tag, " cycles"}, cyc, exp_cyc);
        chk({tag, " signature"}, int'(signature), int'(t.exp_sig));
        chk({tag, " vec_count"}, int'(vec_count), t.exp_cnt);
        chk({tag, " timeout_err"}, int'(timeout_err), int'(t.exp_err));
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " mac_req"}, int'(mac_req), 0);
        chk({tag, " num_issued"}, got.size(), vecs.size());
        for (int i = 0; i < vecs.size() && i < got.size(); i++)
            chk($sformatf("%s vec%0d", tag, i), int'(got[i]), int'(vecs[i]));
    endtask

    initial begin : main
        tv_t tbl[$];
        tv_t t;
        logic [7:0] vq[$];
        rst_n = 1'b0; start = 1'b0; seed = 8'h00; num_vec = 8'h00; step = 1'b1;

        //            seed   n    lat  key    poke sig    cnt err
        tbl.push_back('{8'hA5, 2,   2, 8'h00, 0, 8'h00, 2, 0});
        tbl.push_back('{8'hA5, 1,   2, 8'h00, 0, 8'hA5, 1, 0});
        tbl.push_back('{8'h5A, 0,   2, 8'h00, 0, 8'h00, 0, 0});
        tbl.push_back('{8'h3C, 4, 200, 8'h00, 0, 8'h00, 0, 1});
        tbl.push_back('{8'hA5, 2,   2, 8'h00, 1, 8'h00, 2, 0});
        tbl.push_back('{8'h00, 1,   1, 8'h00, 0, 8'h01, 1, 0});
        tbl.push_back('{8'h11, 1,  15, 8'h00, 0, 8'h11, 1, 0});
        tbl.push_back('{8'h11, 1,  16, 8'h00, 0, 8'h00, 0, 1});
        for (int i = 0; i < 13; i++) begin
            t.seed = 8'($urandom);
            t.n    = (i == 12) ? 255 : int'($urandom_range(1, 10));
            t.lat  = (i == 12) ? 1 : ((i % 5 == 4) ? 20 : int'($urandom_range(1, 5)));
            t.key  = 8'($urandom);
            t.poke = (i % 3 == 0);
            ref_run(t.seed, t.n, t.lat, t.key, t.exp_sig, t.exp_cnt, t.exp_err, vq);
            tbl.push_back(t);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset mac_req", int'(mac_req), 0);
        chk("reset signature", int'(signature), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) run(tbl[i], $sformatf("tv%0d", i));

        // Async reset in the middle of WAIT.
        cur_lat = 5; cur_key = 8'h00;
        @(negedge clk);
        seed = 8'h77; num_vec = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-reset mac_req", int'(mac_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async mac_req", int'(mac_req), 0);
        chk("async busy", int'(busy), 0);
        chk("async vec_count", int'(vec_count), 0);
        chk("async signature", int'(signature), 0);
        chk("async mac_din", int'(mac_din), 0);
        chk("async done", int'(done) | int'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        t = '{8'hA5, 2, 2, 8'h00, 0, 8'h00, 2, 0};
        run(t, "post_reset");

`ifdef MACRO_TEST_STEP_EN
        // Single-step: each HOLD needs one step pulse.
        cur_lat = 1; cur_key = 8'h00;
        step = 1'b0;
        @(negedge clk);
        seed = 8'h42; num_vec = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            repeat (10) @(negedge clk);
            chk($sformatf("hold%0d busy", p), int'(busy), 1);
            chk($sformatf("hold%0d done", p), int'(done), 0);
            chk($sformatf("hold%0d vec_count", p), int'(vec_count), p);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("step done", int'(done), 1);
        chk("step busy", int'(busy), 0);
        chk("step vec_count", int'(vec_count), 3);
        step = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/macro_test_sequencer.md
Name: macro_test_sequencer

Overview:
- BIST-style controller that sequences the blackbox GDS macro under test.
- Generates pseudo-random input vectors (Galois LFSR) and issues each one to the macro over a req/ack handshake.
- Compresses macro responses into a MISR signature and reports done / timeout status.
- Sits inside the TT user wrapper, between the wrapper pins (ui_in/uo_out/uio) and the macro instance.

Parameters:
- DATA_W, 8: width of macro data in/out, LFSR and signature.
- CNT_W, 8: width of vector-count request and counter.
- TIMEOUT, 15: maximum cycles in WAIT without ack before error; must be ≥ 1.
- POLY, 8'hB8: Galois feedback taps, shared by LFSR and MISR.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: rising-edge detected; launches a run.
- seed, in, DATA_W: LFSR seed, sampled on the start edge.
- num_vec, in, CNT_W: vectors to run, sampled on the start edge.
- step, in, 1: single-step advance pulse (see Optional Feature).
- mac_req, out, 1: request to macro.
- mac_din, out, DATA_W: vector to macro.
- mac_ack, in, 1: macro acknowledge; mac_dout is valid in the same cycle.
- mac_dout, in, DATA_W: macro response.
- busy, out, 1: run in progress.
- done, out, 1: run finished, success or error.
- timeout_err, out, 1: run aborted on timeout.
- vec_count, out, CNT_W: vectors completed.
- signature, out, DATA_W: MISR value.

Behaviour:
- Reset (async): state IDLE; all outputs 0; start edge detector cleared.
- step(x): (x>>1) ^ (x[0] ? POLY : 0).
- Start edge in IDLE or DONE:
  - latch num_vec.
  - lfsr = (seed==0) ? 1 : seed.
  - signature=0, vec_count=0, done=0, timeout_err=0.
  - go to ISSUE, or DONE directly if num_vec==0.
- Start edges while busy are ignored.
- ISSUE (1 cycle): drive mac_din=lfsr, mac_req=1; go to WAIT with timer cleared.
- WAIT:
  - Hold mac_req=1 and mac_din stable. Timer increments each cycle without ack.
  - mac_ack=1 sampled:
    - signature <= step(signature) ^ mac_dout;
    - vec_count++, lfsr <= step(lfsr);
    - mac_req drops next cycle; go to GAP.
  - Ack in the same cycle the timer reaches TIMEOUT: ack wins.
  - Timer == TIMEOUT with no ack: go to ERR.
- GAP (1 cycle, mac_req=0): vec_count==num_vec goes to DONE, else ISSUE.
  - Minimum 3 cycles per vector: ISSUE, ≥1 WAIT, GAP.
- DONE: busy=0, done=1; hold signature and vec_count until the next start.
- ERR: mac_req=0, timeout_err=1, done=1, busy=0; vec_count holds completed vectors. ERR and DONE are both restartable by start.
- busy=1 in ISSUE/WAIT/GAP. Registered outputs; no combinational path from mac_ack to mac_req.
- vec_count never wraps; num_vec maximum = 2^CNT_W-1.
- Reset mid-run: mac_req falls immediately; no partial state survives.

Optional Feature:
- MACRO_TEST_STEP_EN defined: GAP waits in a HOLD state until a step pulse (level-high for one sampled cycle) before evaluating next/done; busy stays 1 while holding.
- Undefined: step is ignored and GAP proceeds unconditionally.

Decomposition:
- Package macro_test_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, GAP, HOLD, DONE, ERR);
  - the galois_step function parameterised on POLY;
  - default POLY and TIMEOUT constants.
- One sub-module, macro_test_lfsr: seedable vector generator with load/advance and zero-seed substitution.
- MISR and timer stay inline.

Test Plan:
- Echo macro (mac_dout=mac_din, ack 2 cycles after req), seed=A5, num_vec=2:
  - vectors A5 then EA; signature=00, vec_count=2, done=1, timeout_err=0.
- Same macro, seed=A5, num_vec=1: signature=A5, vec_count=1.
- num_vec=0: done=1 one cycle after the start edge; mac_req never asserts; signature=00.
- Macro never acks, TIMEOUT=15:
  - ERR after 15 WAIT cycles; timeout_err=1, done=1, vec_count=0, mac_req=0.
  - A new start clears the error.
- seed=00: first mac_din=01.
- Async rst_n low during WAIT: all outputs 0 without a clock edge.
- Start pulses while busy are ignored: run completes unchanged.
- With MACRO_TEST_STEP_EN, num_vec=3: exactly 3 step pulses are needed to reach DONE; busy stays 1 between them.
